// File: rtl/fpu_addsub_feeder_if.sv
// Request and issue channels of the fpu_addsub feeder.
// The feeder uses the slave view; the producer side uses the master view.
interface fpu_addsub_feeder_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [1:0]  in_rmode;
  logic [63:0] in_opa;
  logic [63:0] in_opb;

  logic        fpu_enable;
  logic        fpu_op;
  logic [1:0]  fpu_rmode;
  logic [63:0] fpu_opa;
  logic [63:0] fpu_opb;

  modport master (
    output in_valid, in_op, in_rmode, in_opa, in_opb,
    input  in_ready,
    input  fpu_enable, fpu_op, fpu_rmode, fpu_opa, fpu_opb
  );

  modport slave (
    input  in_valid, in_op, in_rmode, in_opa, in_opb,
    output in_ready,
    output fpu_enable, fpu_op, fpu_rmode, fpu_opa, fpu_opb
  );
endinterface

// File: rtl/fpu_addsub_feeder.sv
// Issue stage for fpu_addsub: request FIFO, credit-limited issue and a
// tag delay line aligned with the fpu_addsub result latency.
module fpu_addsub_feeder #(
  parameter int DEPTH   = 4,
  parameter int LAT     = 24,
  parameter int CREDITS = 8,
  parameter int TAGW    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fpu_addsub_feeder_if.slave         bus,
  input  logic                       res_pop,
  output logic                       tag_valid,
  output logic [TAGW-1:0]            tag,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [$clog2(CREDITS):0]   outstanding,
  output logic                       err_pop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(CREDITS) + 1;
  localparam logic [CW-1:0] FIFO_FULL   = CW'(DEPTH);
  localparam logic [OW-1:0] CREDIT_MAX  = OW'(CREDITS);

  typedef struct packed {
    logic        op;
    logic [1:0]  rmode;
    logic [63:0] opa;
    logic [63:0] opb;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TAGW-1:0] tag_cnt;
  logic [TAGW-1:0] issue_tag;
  logic [TAGW:0]   dly [LAT];

  logic push;
  logic issue;
  logic pop_ok;

  // in_ready depends only on registered occupancy, so a full FIFO never refills in the issuing cycle
  assign bus.in_ready = rst && (fifo_count != FIFO_FULL);
  assign push         = bus.in_valid && bus.in_ready;
  assign issue        = (fifo_count != '0) && (outstanding < CREDIT_MAX);
  assign pop_ok       = res_pop && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: bus.in_op, rmode: bus.in_rmode,
                       opa: bus.in_opa, opb: bus.in_opb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, issue})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      outstanding <= '0;
      err_pop     <= 1'b0;
    end else begin
      case ({issue, pop_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (res_pop && (outstanding == '0)) begin
        err_pop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.fpu_enable <= 1'b0;
      bus.fpu_op     <= 1'b0;
      bus.fpu_rmode  <= '0;
      bus.fpu_opa    <= '0;
      bus.fpu_opb    <= '0;
      tag_cnt        <= '0;
      issue_tag      <= '0;
    end else begin
      bus.fpu_enable <= issue;
      if (issue) begin
        bus.fpu_op    <= mem[rd_ptr].op;
        bus.fpu_rmode <= mem[rd_ptr].rmode;
        bus.fpu_opa   <= mem[rd_ptr].opa;
        bus.fpu_opb   <= mem[rd_ptr].opb;
        issue_tag     <= tag_cnt;
        tag_cnt       <= tag_cnt + 1'b1;
      end
    end
  end

  // Fed from the registered enable, so the last stage lands LAT cycles after the fpu_enable cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        dly[i] <= '0;
      end
    end else begin
      dly[0] <= {bus.fpu_enable, issue_tag};
      for (int i = 1; i < LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign tag_valid = dly[LAT-1][TAGW];
  assign tag       = dly[LAT-1][TAGW-1:0];

endmodule

// File: tb/tb_fpu_addsub_feeder.sv
// Directed-plus-random bench for fpu_addsub_feeder, checked cycle by cycle
// against a queue-based reference model of the issue stage.
module tb_fpu_addsub_feeder;

  localparam int DEPTH   = 4;
  localparam int LAT     = 24;
  localparam int CREDITS = 8;
  localparam int TAGW    = 4;

  typedef struct packed {
    logic        op;
    logic [1:0]  rmode;
    logic [63:0] opa;
    logic [63:0] opb;
  } req_t;

  logic            clk;
  logic            rst;
  logic            res_pop;
  logic            tag_valid;
  logic [TAGW-1:0] tag;
  logic [2:0]      fifo_count;
  logic [3:0]      outstanding;
  logic            err_pop;

  fpu_addsub_feeder_if bus ();

  fpu_addsub_feeder #(
    .DEPTH(DEPTH), .LAT(LAT), .CREDITS(CREDITS), .TAGW(TAGW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .res_pop    (res_pop),
    .tag_valid  (tag_valid),
    .tag        (tag),
    .fifo_count (fifo_count),
    .outstanding(outstanding),
    .err_pop    (err_pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  req_t            m_q[$];
  int              m_out;
  logic [TAGW-1:0] m_tagc;
  bit              m_err;
  bit              m_en;
  req_t            m_last;
  int              ev_due[$];
  logic [TAGW-1:0] ev_tag[$];
  bit              m_tv;
  logic [TAGW-1:0] m_tag;
  bit              m_acc;

  req_t idle_req;
  req_t fixed_req;
  int   acc;

  task automatic checkOutput(input string name, input logic [63:0] obs,
                             input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)",
             name, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input req_t d, input bit p);
    rst          = r;
    bus.in_valid = v;
    bus.in_op    = d.op;
    bus.in_rmode = d.rmode;
    bus.in_opa   = d.opa;
    bus.in_opb   = d.opb;
    res_pop      = p;
  endtask

  function automatic req_t rand_req();
    req_t q;
    q.op    = 1'($urandom_range(0, 1));
    q.rmode = 2'($urandom_range(0, 3));
    q.opa   = {$urandom, $urandom};
    q.opb   = {$urandom, $urandom};
    return q;
  endfunction

  // One clock: drive, evaluate the model's decisions, cross the edge, compare
  task automatic step(input bit r, input bit v, input req_t d, input bit p);
    bit push, issue, popok;
    applyStimulus(r, v, d, p);
    push  = v && r && (m_q.size() != DEPTH);
    issue = (m_q.size() != 0) && (m_out < CREDITS);
    popok = p && (m_out != 0);
    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      m_q.delete();
      ev_due.delete();
      ev_tag.delete();
      m_out  = 0;
      m_tagc = '0;
      m_err  = 1'b0;
      m_en   = 1'b0;
      m_last = '0;
      m_tag  = '0;
      push   = 1'b0;
    end else begin
      if (p && m_out == 0) m_err = 1'b1;
      m_en = issue;
      if (issue) begin
        m_last = m_q.pop_front();
        ev_due.push_back(cyc + LAT);
        ev_tag.push_back(m_tagc);
        m_tagc = m_tagc + 1'b1;
      end
      if (push) m_q.push_back(d);
      m_out = m_out + int'(issue) - int'(popok);
    end
    m_acc = push;
    m_tv  = (ev_due.size() != 0) && (ev_due[0] == cyc);
    if (m_tv) begin
      m_tag = ev_tag[0];
      void'(ev_due.pop_front());
      void'(ev_tag.pop_front());
    end

    checkOutput("in_ready",    64'(bus.in_ready),   64'(r && (m_q.size() != DEPTH)));
    checkOutput("fifo_count",  64'(fifo_count),     64'(m_q.size()));
    checkOutput("outstanding", 64'(outstanding),    64'(m_out));
    checkOutput("fpu_enable",  64'(bus.fpu_enable), 64'(m_en));
    checkOutput("fpu_op",      64'(bus.fpu_op),     64'(m_last.op));
    checkOutput("fpu_rmode",   64'(bus.fpu_rmode),  64'(m_last.rmode));
    checkOutput("fpu_opa",     bus.fpu_opa,         m_last.opa);
    checkOutput("fpu_opb",     bus.fpu_opb,         m_last.opb);
    checkOutput("tag_valid",   64'(tag_valid),      64'(m_tv));
    if (m_tv || !r) checkOutput("tag", 64'(tag), 64'(m_tag));
    checkOutput("err_pop",     64'(err_pop),        64'(m_err));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_req  = '0;
    fixed_req = '{op: 1'b1, rmode: 2'd2,
                  opa: 64'h4030000000000000, opb: 64'h14C0701BD527B498};
    m_out  = 0;
    m_tagc = '0;
    m_err  = 1'b0;
    m_en   = 1'b0;
    m_last = '0;
    m_tv   = 1'b0;
    m_tag  = '0;
    applyStimulus(1'b0, 1'b0, idle_req, 1'b0);

    repeat (3) step(1'b0, 1'b0, idle_req, 1'b0);

    // Single operation, result popped when its tag comes out
    step(1'b1, 1'b1, fixed_req, 1'b0);
    checkOutput("single_accept", 64'(m_acc), 64'd1);
    repeat (30) step(1'b1, 1'b0, idle_req, m_tv);

    // Streaming 17 requests so the tag wraps
    acc = 0;
    for (int i = 0; i < 300 && acc < 17; i++) begin
      step(1'b1, 1'b1, rand_req(), m_tv);
      if (m_acc) acc++;
    end
    checkOutput("stream_accepted", 64'(acc), 64'd17);
    for (int i = 0; i < 400 && (m_q.size() != 0 || m_out != 0); i++)
      step(1'b1, 1'b0, idle_req, m_tv);
    checkOutput("stream_drained", 64'(m_out), 64'd0);

    // Full FIFO with credits exhausted
    acc = 0;
    for (int i = 0; i < 100 && acc < 12; i++) begin
      step(1'b1, 1'b1, rand_req(), 1'b0);
      if (m_acc) acc++;
    end
    checkOutput("full_accepted", 64'(acc), 64'd12);
    repeat (4) step(1'b1, 1'b1, rand_req(), 1'b0);
    checkOutput("full_count", 64'(fifo_count), 64'd4);
    checkOutput("full_credits", 64'(outstanding), 64'd8);
    checkOutput("full_ready", 64'(bus.in_ready), 64'd0);
    step(1'b1, 1'b0, idle_req, 1'b1);
    step(1'b1, 1'b0, idle_req, 1'b0);
    checkOutput("one_credit_issue", 64'(fifo_count), 64'd3);
    repeat (3) step(1'b1, 1'b0, idle_req, 1'b0);
    for (int i = 0; i < 100 && (m_q.size() != 0 || m_out != 0); i++)
      step(1'b1, 1'b0, idle_req, m_out != 0);
    checkOutput("full_drained", 64'(m_out), 64'd0);

    // Push, issue and pop on the same edge
    step(1'b1, 1'b1, rand_req(), 1'b0);
    step(1'b1, 1'b1, rand_req(), 1'b0);
    step(1'b1, 1'b1, rand_req(), 1'b1);
    checkOutput("simul_count", 64'(fifo_count), 64'd1);
    checkOutput("simul_credits", 64'(outstanding), 64'd1);
    for (int i = 0; i < 100 && (m_q.size() != 0 || m_out != 0); i++)
      step(1'b1, 1'b0, idle_req, m_out != 0);
    repeat (LAT + 2) step(1'b1, 1'b0, idle_req, 1'b0);

    // Spurious pop sets the sticky error
    step(1'b1, 1'b0, idle_req, 1'b1);
    checkOutput("spurious_err", 64'(err_pop), 64'd1);
    checkOutput("spurious_credits", 64'(outstanding), 64'd0);
    repeat (5) step(1'b1, 1'b1, rand_req(), 1'b0);
    checkOutput("err_sticky", 64'(err_pop), 64'd1);

    // Reset with operations in flight
    repeat (3) step(1'b1, 1'b0, idle_req, 1'b0);
    step(1'b0, 1'b0, idle_req, 1'b0);
    checkOutput("reset_err", 64'(err_pop), 64'd0);
    checkOutput("reset_enable", 64'(bus.fpu_enable), 64'd0);
    repeat (30) step(1'b1, 1'b0, idle_req, 1'b0);

    // Random traffic with occasional resets
    repeat (600)
      step($urandom_range(0, 149) != 0, 1'($urandom_range(0, 1)), rand_req(),
           (m_out != 0) && ($urandom_range(0, 2) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
